// File: rtl/ula_pkg.sv
// +------------------------------------------------------------------+
// | ula_pkg: opcodes of the shared 8-bit ula and arbiter FSM states   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package ula_pkg;

  localparam logic [3:0] ULA_SOMA = 4'd0;
  localparam logic [3:0] ULA_SUB  = 4'd1;
  localparam logic [3:0] ULA_INC  = 4'd2;
  localparam logic [3:0] ULA_DEC  = 4'd3;
  localparam logic [3:0] ULA_SHL  = 4'd4;
  localparam logic [3:0] ULA_SHR  = 4'd5;
  localparam logic [3:0] ULA_ROL  = 4'd6;
  localparam logic [3:0] ULA_ROR  = 4'd7;
  localparam logic [3:0] ULA_AND  = 4'd8;
  localparam logic [3:0] ULA_OR   = 4'd9;
  localparam logic [3:0] ULA_XOR  = 4'd10;
  localparam logic [3:0] ULA_XNOR = 4'd11;

  localparam int ULA_OP_MAX = 11;

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EMITE    = 2'd1,
    CAPTURA  = 2'd2,
    RESPONDE = 2'd3
  } arb_estado_t;

endpackage

`default_nettype wire

// File: rtl/arbitro_rr.sv
// +------------------------------------------------------------------+
// | arbitro_rr: 2-input grant logic with last-granted pointer.        |
// | ULA_ARB_PRIO_FIXA_EN selects fixed priority (requester 0 wins).   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module arbitro_rr (
  input  logic clock,
  input  logic resetN,
  input  logic valid0,
  input  logic valid1,
  input  logic aceita,
  output logic grant
);

`ifdef ULA_ARB_PRIO_FIXA_EN
  logic unused_sinais;
  assign unused_sinais = &{1'b0, clock, resetN, aceita};
  assign grant = valid1 && !valid0;
`else
  logic ultimo;

  // Pointer holds the last winner; it starts at 1 so requester 0 takes the first tie.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)
      ultimo <= 1'b1;
    else if (aceita)
      ultimo <= grant;
  end

  always_comb begin
    grant = valid1;
    if (valid0 && valid1)
      grant = ~ultimo;
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ula_arbitro.sv
// +------------------------------------------------------------------+
// | ula_arbitro: shares one external ula between two requesters,      |
// | sequencing issue/capture/response. Macro: ULA_ARB_PRIO_FIXA_EN    |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module ula_arbitro
  import ula_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int OP_MAX  = ULA_OP_MAX
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               req0Valid,
  output logic               req0Ready,
  input  logic [LARGURA-1:0] req0A,
  input  logic [LARGURA-1:0] req0B,
  input  logic [3:0]         req0Op,
  input  logic               req1Valid,
  output logic               req1Ready,
  input  logic [LARGURA-1:0] req1A,
  input  logic [LARGURA-1:0] req1B,
  input  logic [3:0]         req1Op,
  output logic               resp0Valid,
  input  logic               resp0Ready,
  output logic [LARGURA:0]   resp0Dado,
  output logic               resp0Erro,
  output logic               resp1Valid,
  input  logic               resp1Ready,
  output logic [LARGURA:0]   resp1Dado,
  output logic               resp1Erro,
  output logic [LARGURA-1:0] ulaA,
  output logic [LARGURA-1:0] ulaB,
  output logic [3:0]         ulaOp,
  input  logic [LARGURA:0]   ulaSaida,
  output logic               ocupado
);

  localparam logic [3:0] OP_LIM = 4'(OP_MAX);

  arb_estado_t        estado;
  arb_estado_t        prox;
  logic               grant;
  logic               ocioso;
  logic               aceita;
  logic               op_ilegal;
  logic               id;
  logic               resp_ready;
  logic [LARGURA-1:0] sel_a;
  logic [LARGURA-1:0] sel_b;
  logic [3:0]         sel_op;
  logic [LARGURA:0]   dado;
  logic               erro;

  arbitro_rr u_arbitro (
    .clock  (clock),
    .resetN (resetN),
    .valid0 (req0Valid),
    .valid1 (req1Valid),
    .aceita (aceita),
    .grant  (grant)
  );

  assign ocioso     = (estado == OCIOSO);
  assign sel_a      = grant ? req1A  : req0A;
  assign sel_b      = grant ? req1B  : req0B;
  assign sel_op     = grant ? req1Op : req0Op;
  assign op_ilegal  = (sel_op > OP_LIM);
  assign aceita     = ocioso && (grant ? req1Valid : req0Valid);
  assign resp_ready = id ? resp1Ready : resp0Ready;

  // The state register reads OCIOSO during reset, so readies are also gated by resetN.
  assign req0Ready  = resetN && ocioso && !grant;
  assign req1Ready  = resetN && ocioso && grant;
  assign resp0Valid = (estado == RESPONDE) && !id;
  assign resp1Valid = (estado == RESPONDE) && id;
  assign resp0Dado  = dado;
  assign resp1Dado  = dado;
  assign resp0Erro  = erro;
  assign resp1Erro  = erro;
  assign ocupado    = !ocioso;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)
      estado <= OCIOSO;
    else
      estado <= prox;
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:   if (aceita) prox = op_ilegal ? RESPONDE : EMITE;
      EMITE:    prox = CAPTURA;
      CAPTURA:  prox = RESPONDE;
      RESPONDE: if (resp_ready) prox = OCIOSO;
      default:  prox = OCIOSO;
    endcase
  end

  // A rejected opcode leaves the ALU operand registers untouched.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      id    <= 1'b0;
      dado  <= '0;
      erro  <= 1'b0;
      ulaA  <= '0;
      ulaB  <= '0;
      ulaOp <= '0;
    end else begin
      if (aceita) begin
        id <= grant;
        if (op_ilegal) begin
          dado <= '0;
          erro <= 1'b1;
        end else begin
          ulaA  <= sel_a;
          ulaB  <= sel_b;
          ulaOp <= sel_op;
        end
      end
      if (estado == CAPTURA) begin
        dado <= ulaSaida;
        erro <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ula_arbitro.sv
// +------------------------------------------------------------------+
// | tb_ula_arbitro: scoreboard bench for ula_arbitro with a           |
// | registered ula model on the ula* ports.  rev 1.0                  |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ula_arbitro;
  import ula_pkg::*;

  logic       clock = 1'b0;
  logic       resetN = 1'b0;
  logic       req0Valid = 1'b0, req1Valid = 1'b0;
  logic       req0Ready, req1Ready;
  logic [7:0] req0A = '0, req0B = '0, req1A = '0, req1B = '0;
  logic [3:0] req0Op = '0, req1Op = '0;
  logic       resp0Valid, resp1Valid;
  logic       resp0Ready = 1'b1, resp1Ready = 1'b1;
  logic [8:0] resp0Dado, resp1Dado;
  logic       resp0Erro, resp1Erro;
  logic [7:0] ulaA, ulaB;
  logic [3:0] ulaOp;
  logic [8:0] ulaSaida;
  logic       ocupado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [8:0] dado;
    logic       erro;
  } esp_t;
  esp_t fila[$];

  logic [7:0] exp_a = '0, exp_b = '0;
  logic [3:0] exp_op = '0;

  ula_arbitro dut (
    .clock(clock), .resetN(resetN),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0A(req0A), .req0B(req0B), .req0Op(req0Op),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1A(req1A), .req1B(req1B), .req1Op(req1Op),
    .resp0Valid(resp0Valid), .resp0Ready(resp0Ready), .resp0Dado(resp0Dado), .resp0Erro(resp0Erro),
    .resp1Valid(resp1Valid), .resp1Ready(resp1Ready), .resp1Dado(resp1Dado), .resp1Erro(resp1Erro),
    .ulaA(ulaA), .ulaB(ulaB), .ulaOp(ulaOp), .ulaSaida(ulaSaida), .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  // Registered ALU standing in for the external ula.
  always @(posedge clock) begin
    case (ulaOp)
      ULA_SOMA: ulaSaida <= {1'b0, ulaA} + {1'b0, ulaB};
      ULA_SUB:  ulaSaida <= {1'b0, ulaA} - {1'b0, ulaB};
      ULA_AND:  ulaSaida <= {1'b0, ulaA & ulaB};
      ULA_OR:   ulaSaida <= {1'b0, ulaA | ulaB};
      ULA_XOR:  ulaSaida <= {1'b0, ulaA ^ ulaB};
      ULA_XNOR: ulaSaida <= {1'b0, ~(ulaA ^ ulaB)};
      default:  ulaSaida <= 9'h000;
    endcase
  end

  // Scoreboard: every completed response handshake pops one expectation.
  always @(negedge clock) begin
    checks++;
    if (resp0Valid && resp1Valid) begin
      errors++;
      $display("FAIL resp_exclusive: both respValid high at %0t", $time);
    end
    if (resp0Valid && resp0Ready) begin
      checks++;
      if (fila.size() == 0) begin
        errors++;
        $display("FAIL resp0_unexpected: dado=%h erro=%b, no response expected", resp0Dado, resp0Erro);
      end else begin
        esp_t e;
        e = fila.pop_front();
        if ({1'b0, resp0Dado, resp0Erro} !== {e.id, e.dado, e.erro}) begin
          errors++;
          $display("FAIL resp0_data: got id=0 dado=%h erro=%b, want id=%b dado=%h erro=%b",
                   resp0Dado, resp0Erro, e.id, e.dado, e.erro);
        end
      end
    end
    if (resp1Valid && resp1Ready) begin
      checks++;
      if (fila.size() == 0) begin
        errors++;
        $display("FAIL resp1_unexpected: dado=%h erro=%b, no response expected", resp1Dado, resp1Erro);
      end else begin
        esp_t e;
        e = fila.pop_front();
        if ({1'b1, resp1Dado, resp1Erro} !== {e.id, e.dado, e.erro}) begin
          errors++;
          $display("FAIL resp1_data: got id=1 dado=%h erro=%b, want id=%b dado=%h erro=%b",
                   resp1Dado, resp1Erro, e.id, e.dado, e.erro);
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge clock);
    #2;
  endtask

  task automatic wait_ready(input logic id, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (id ? req1Ready : req0Ready) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_timeout: req%0d ready=0, want 1 within 20 cycles", id);
    end
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clock);
      if (!ocupado) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout: ocupado=%b, want 0 within 30 cycles", ocupado);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({req0Ready, req1Ready, resp0Valid, resp1Valid, resp0Dado, resp0Erro, resp1Dado, resp1Erro,
         ulaA, ulaB, ulaOp, ocupado} !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b%b rv=%b%b d=%h/%h e=%b%b ula=%h/%h/%h ocup=%b, want all 0",
               req0Ready, req1Ready, resp0Valid, resp1Valid, resp0Dado, resp1Dado, resp0Erro, resp1Erro,
               ulaA, ulaB, ulaOp, ocupado);
    end
    drive_edge();
    resetN = 1'b1;
  endtask

  task automatic test_soma();
    logic ok;
    drive_edge();
    req0Valid = 1'b1; req0A = 8'd200; req0B = 8'd100; req0Op = ULA_SOMA;
    wait_ready(1'b0, ok);
    fila.push_back('{1'b0, 9'h12C, 1'b0});
    exp_a = 8'd200; exp_b = 8'd100; exp_op = ULA_SOMA;
    drive_edge();
    req0Valid = 1'b0;
    @(negedge clock);
    checks++;
    if (ulaA !== exp_a || ulaB !== exp_b || ulaOp !== exp_op || resp0Valid !== 1'b0 || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL soma_issue: ula=%h/%h/%h rv=%b ocup=%b, want %h/%h/%h 0 1",
               ulaA, ulaB, ulaOp, resp0Valid, ocupado, exp_a, exp_b, exp_op);
    end
    @(negedge clock);
    checks++;
    if (resp0Valid !== 1'b0) begin
      errors++;
      $display("FAIL soma_early: resp0Valid=%b one cycle after accept, want 0", resp0Valid);
    end
    @(negedge clock);
    checks++;
    if (resp0Valid !== 1'b1) begin
      errors++;
      $display("FAIL soma_latency: resp0Valid=%b two cycles after accept, want 1", resp0Valid);
    end
    wait_idle();
  endtask

  task automatic test_sub();
    logic ok;
    drive_edge();
    req1Valid = 1'b1; req1A = 8'd5; req1B = 8'd10; req1Op = ULA_SUB;
    wait_ready(1'b1, ok);
    fila.push_back('{1'b1, 9'h1FB, 1'b0});
    exp_a = 8'd5; exp_b = 8'd10; exp_op = ULA_SUB;
    drive_edge();
    req1Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (resp0Valid !== 1'b0) begin
        errors++;
        $display("FAIL sub_resp0_quiet: resp0Valid=%b, want 0", resp0Valid);
      end
    end
    wait_idle();
  endtask

  task automatic test_tie();
    logic g, got;
    int   n;
    logic esperado[4];
`ifdef ULA_ARB_PRIO_FIXA_EN
    esperado = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    esperado = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    drive_edge();
    req0Valid = 1'b1; req0A = 8'hF0; req0B = 8'h3C; req0Op = ULA_AND;
    req1Valid = 1'b1; req1A = 8'hF0; req1B = 8'h3C; req1Op = ULA_XOR;
    n = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clock);
      got = 1'b0; g = 1'b0;
      if (req0Ready) begin got = 1'b1; g = 1'b0; end
      else if (req1Ready) begin got = 1'b1; g = 1'b1; end
      if (got) begin
        checks++;
        if (g !== esperado[n]) begin
          errors++;
          $display("FAIL tie_grant%0d: granted req%0d, want req%0d", n, g, esperado[n]);
        end
        fila.push_back('{g, (g ? 9'h0CC : 9'h030), 1'b0});
        exp_a = 8'hF0; exp_b = 8'h3C; exp_op = g ? ULA_XOR : ULA_AND;
        n++;
      end
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL tie_timeout: %0d grants seen, want 4", n);
    end
    drive_edge();
    req0Valid = 1'b0; req1Valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_illegal();
    logic ok;
    drive_edge();
    req0Valid = 1'b1; req0A = 8'h11; req0B = 8'h22; req0Op = 4'hC;
    wait_ready(1'b0, ok);
    fila.push_back('{1'b0, 9'h000, 1'b1});
    drive_edge();
    req0Valid = 1'b0;
    @(negedge clock);
    checks++;
    if (resp0Valid !== 1'b1 || resp0Erro !== 1'b1 || resp0Dado !== 9'h000) begin
      errors++;
      $display("FAIL illegal_resp: rv=%b erro=%b dado=%h, want 1 1 000", resp0Valid, resp0Erro, resp0Dado);
    end
    checks++;
    if (ulaA !== exp_a || ulaB !== exp_b || ulaOp !== exp_op) begin
      errors++;
      $display("FAIL illegal_ula_kept: ula=%h/%h/%h, want %h/%h/%h", ulaA, ulaB, ulaOp, exp_a, exp_b, exp_op);
    end
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic ok;
    drive_edge();
    resp0Ready = 1'b0;
    req0Valid = 1'b1; req0A = 8'd1; req0B = 8'd2; req0Op = ULA_SOMA;
    wait_ready(1'b0, ok);
    fila.push_back('{1'b0, 9'h003, 1'b0});
    drive_edge();
    req0Valid = 1'b0;
    req1Valid = 1'b1; req1A = 8'd7; req1B = 8'd3; req1Op = ULA_SUB;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clock);
      if (resp0Valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_resp_timeout: resp0Valid=0, want 1 within 10 cycles");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (resp0Dado !== 9'h003 || resp0Valid !== 1'b1 || req0Ready !== 1'b0 || req1Ready !== 1'b0 || ocupado !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d: dado=%h rv=%b rdy=%b%b ocup=%b, want 003 1 00 1",
                 i, resp0Dado, resp0Valid, req0Ready, req1Ready, ocupado);
      end
    end
    drive_edge();
    resp0Ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (req1Ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: req1Ready=%b after response, want 1", req1Ready);
    end
    fila.push_back('{1'b1, 9'h004, 1'b0});
    exp_a = 8'd7; exp_b = 8'd3; exp_op = ULA_SUB;
    drive_edge();
    req1Valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic ok;
    drive_edge();
    req0Valid = 1'b1; req0A = 8'd9; req0B = 8'd9; req0Op = ULA_SOMA;
    wait_ready(1'b0, ok);
    drive_edge();
    req0Valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    resetN = 1'b0;
    #1;
    checks++;
    if ({req0Ready, req1Ready, resp0Valid, resp1Valid, resp0Dado, resp0Erro,
         ulaA, ulaB, ulaOp, ocupado} !== '0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b%b rv=%b%b d=%h e=%b ula=%h/%h/%h ocup=%b, want all 0",
               req0Ready, req1Ready, resp0Valid, resp1Valid, resp0Dado, resp0Erro, ulaA, ulaB, ulaOp, ocupado);
    end
    drive_edge();
    resetN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if (resp0Valid !== 1'b0 || resp1Valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_dropped: rv=%b%b after reset, want 00", resp0Valid, resp1Valid);
      end
    end
    drive_edge();
    req0Valid = 1'b1; req0A = 8'hF0; req0B = 8'h3C; req0Op = ULA_AND;
    req1Valid = 1'b1; req1A = 8'hF0; req1B = 8'h3C; req1Op = ULA_XOR;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (req0Ready || req1Ready) ok = 1'b1;
    end
    checks++;
    if (!ok || req0Ready !== 1'b1 || req1Ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_tie: rdy=%b%b, want req0 granted (10)", req0Ready, req1Ready);
    end
    fila.push_back('{1'b0, 9'h030, 1'b0});
    drive_edge();
    req0Valid = 1'b0; req1Valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_soma();
    test_sub();
    test_tie();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    repeat (4) @(negedge clock);
    checks++;
    if (fila.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", fila.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, want completion before 200000");
    $fatal(1);
  end

endmodule

`default_nettype wire
